toggle_pulse_gen: RTL and testbench

Upstream stage for the T flip-flop: turns a raw, asynchronous, bouncing push-button into a clean single-cycle toggle-request pulse that drives the T flip-flop's `t_in`. It synchronises the raw input, debounces it with a counter-based FSM, and emits exactly one `t_out` pulse per accepted press. The debounced level and a busy flag are also exported for status and test.

---
 rtl/toggle_pulse_gen.sv | 108 ++++++++++
 tb/tb_toggle_pulse_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_gen.sv
// Push-button front end: synchronises, debounces and converts each accepted
// press into a single-cycle toggle pulse for a downstream T flip-flop.
module toggle_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t_out,
  output logic btn_level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             t_out_q, t_out_d;
  logic             level_q, level_d;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_out_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_out_q <= t_out_d;
      level_q <= level_d;
    end
  end

  // Counter is cleared on every state change and saturates at CNT_LAST
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_out_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          t_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASING;
          cnt_d   = '0;
        end
      end
      RELEASING: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASING);
  end

  assign t_out     = t_out_q;
  assign btn_level = level_q;
  assign busy      = (state_q == ARMING) || (state_q == RELEASING);

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Randomised and directed bench for toggle_pulse_gen (D=4 and D=1 instances)
// against a run-length debounce model.
module tb_toggle_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic t_out0, level0, busy0;
  logic t_out1, level1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  toggle_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) u_d4 (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .t_out(t_out0), .btn_level(level0), .busy(busy0)
  );

  toggle_pulse_gen #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .t_out(t_out1), .btn_level(level1), .busy(busy1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once D+1 consecutive synchronised
  // samples disagree with it; busy while such a run is in progress.
  int unsigned dv [2] = '{4, 1};
  int          run [2];
  logic        m_lvl [2];
  logic        m_t [2];
  logic        m_busy [2];
  logic [1:0]  hist;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist = 2'b00;
      for (int i = 0; i < 2; i++) begin
        run[i] = 0; m_lvl[i] = 1'b0; m_t[i] = 1'b0; m_busy[i] = 1'b0;
      end
    end else begin
      logic s2;
      s2   = hist[1];
      hist = {hist[0], btn_in};
      for (int i = 0; i < 2; i++) begin
        m_t[i] = 1'b0;
        if (s2 != m_lvl[i]) begin
          run[i]++;
          if (run[i] == int'(dv[i]) + 1) begin
            m_lvl[i] = ~m_lvl[i];
            m_t[i]   = m_lvl[i];
            run[i]   = 0;
          end
        end else begin
          run[i] = 0;
        end
        m_busy[i] = (run[i] != 0);
      end
    end
  end

  always @(negedge clk) begin
    chk("d4 t_out", t_out0, m_t[0]);
    chk("d4 btn_level", level0, m_lvl[0]);
    chk("d4 busy", busy0, m_busy[0]);
    chk("d1 t_out", t_out1, m_t[1]);
    chk("d1 btn_level", level1, m_lvl[1]);
    chk("d1 busy", busy1, m_busy[1]);
  end

  // Downstream T flip-flop driven by the D=4 instance
  logic tq;
  always @(posedge clk or negedge rst) begin
    if (!rst) tq <= 1'b0;
    else if (t_out0) tq <= ~tq;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // btn_in already high; next edge is edge 1
  task automatic press_check(input string tag);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk({tag, " busy"}, busy0, (k >= 3) && (k <= 6));
      chk({tag, " t_out"}, t_out0, k == 7);
      chk({tag, " btn_level"}, level0, k >= 7);
    end
  endtask

  task automatic release_check(input string tag);
    btn_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk({tag, " busy"}, busy0, (k >= 3) && (k <= 6));
      chk({tag, " t_out"}, t_out0, 1'b0);
      chk({tag, " btn_level"}, level0, k < 7);
    end
  endtask

  task automatic bounce(input string tag);
    btn_in = 1'b1; tick(); tick();
    btn_in = 1'b0; tick(); tick(); tick();
    btn_in = 1'b1; tick(); tick();
    btn_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk({tag, " t_out"}, t_out0, 1'b0);
      chk({tag, " btn_level"}, level0, 1'b0);
    end
    chk({tag, " busy idle"}, busy0, 1'b0);
  endtask

  initial begin
    btn_in = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst pre-edge t_out", t_out0, 1'b0);
    chk("rst pre-edge btn_level", level0, 1'b0);
    chk("rst pre-edge busy", busy0, 1'b0);
    tick(); tick();
    chk("rst mid t_out", t_out0, 1'b0);
    chk("rst mid btn_level", level0, 1'b0);
    chk("rst mid busy", busy0, 1'b0);
    rst = 1'b1;
    press_check("held_thru_reset");
    release_check("release1");

    btn_in = 1'b1;
    press_check("clean");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("clean hold t_out", t_out0, 1'b0);
    end
    release_check("release2");

    bounce("bounce");

    btn_in = 1'b1;
    press_check("press3");
    btn_in = 1'b0; tick(); tick();
    btn_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("glitch btn_level", level0, 1'b1);
      chk("glitch t_out", t_out0, 1'b0);
    end
    release_check("release3");

    btn_in = 1'b1;
    repeat (5) tick();
    chk("pre-abort busy", busy0, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort busy", busy0, 1'b0);
    chk("abort t_out", t_out0, 1'b0);
    chk("abort btn_level", level0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    press_check("post_reset");
    release_check("release4");

    btn_in = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    chk("chain q init", tq, 1'b0);
    for (int p = 1; p <= 4; p++) begin
      btn_in = 1'b1; repeat (12) tick();
      btn_in = 1'b0; repeat (12) tick();
      chk("chain q", tq, (p % 2) == 1);
    end
    bounce("chain bounce");
    chk("chain q after bounce", tq, 1'b0);

    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b1;
      end
      btn_in = ~btn_in;
      repeat ($urandom_range(1, 12)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
